// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// mdu_seq : iterative multiply/divide unit with HI/LO result registers.
//           Define MDU_DIV_EN to build the DIVU/DIV datapath.
// Rev 1.0
// ============================================================================
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int            CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [2:0]    OP_MULTU = 3'b000;
  localparam logic [2:0]    OP_MULT  = 3'b001;
  localparam logic [2:0]    OP_MTHI  = 3'b100;
  localparam logic [2:0]    OP_MTLO  = 3'b101;
`ifdef MDU_DIV_EN
  localparam logic [2:0]    OP_DIVU  = 3'b010;
  localparam logic [2:0]    OP_DIV   = 3'b011;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               sgn_lo_q, sgn_lo_d;

  logic [WIDTH-1:0]   a_mag, b_mag, op_a, op_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_fix;

  // Signed ops (op[0]=1) iterate on magnitudes; the sign is re-applied in FIX.
  assign a_mag    = a[WIDTH-1] ? -a : a;
  assign b_mag    = b[WIDTH-1] ? -b : b;
  assign op_a     = op[0] ? a_mag : a;
  assign op_b     = op[0] ? b_mag : b;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign prod_fix = sgn_lo_q ? -acc_q : acc_q;

`ifdef MDU_DIV_EN
  logic               is_div_q, is_div_d;
  logic               sgn_hi_q, sgn_hi_d;
  logic               bz_q, bz_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH:0]     rem_sh, diff;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // acc holds {remainder, dividend/quotient}; one extra bit keeps the trial subtract exact.
  assign rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff    = rem_sh - {1'b0, opnd_q};
  assign quo_fix = sgn_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix = sgn_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    sgn_lo_d = sgn_lo_q;
`ifdef MDU_DIV_EN
    is_div_d = is_div_q;
    sgn_hi_d = sgn_hi_q;
    bz_d     = bz_q;
    a_d      = a_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULTU, OP_MULT: begin
              state_d  = S_MUL;
              busy_d   = 1'b1;
              cnt_d    = '0;
              dz_d     = 1'b0;
              acc_d    = {{WIDTH{1'b0}}, op_b};
              opnd_d   = op_a;
              sgn_lo_d = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MDU_DIV_EN
              is_div_d = 1'b0;
`endif
            end
`ifdef MDU_DIV_EN
            OP_DIVU, OP_DIV: begin
              state_d  = S_DIV;
              busy_d   = 1'b1;
              cnt_d    = '0;
              dz_d     = 1'b0;
              acc_d    = {{WIDTH{1'b0}}, op_a};
              opnd_d   = op_b;
              sgn_lo_d = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
              sgn_hi_d = op[0] & a[WIDTH-1];
              is_div_d = 1'b1;
              bz_d     = (b == '0);
              a_d      = a;
            end
`endif
            OP_MTHI: begin
              hi_d   = a;
              dz_d   = 1'b0;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = a;
              dz_d   = 1'b0;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
`ifdef MDU_DIV_EN
      S_DIV: begin
        if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else              acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
`endif
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          if (bz_q) begin
            hi_d = a_q;
            lo_d = '1;
            dz_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else
`endif
        begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Cancel wins over the FIX write-back; in IDLE a pending start takes precedence.
    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = dz_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      sgn_lo_q <= 1'b0;
`ifdef MDU_DIV_EN
      is_div_q <= 1'b0;
      sgn_hi_q <= 1'b0;
      bz_q     <= 1'b0;
      a_q      <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      sgn_lo_q <= sgn_lo_d;
`ifdef MDU_DIV_EN
      is_div_q <= is_div_d;
      sgn_hi_q <= sgn_hi_d;
      bz_q     <= bz_d;
      a_q      <= a_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// ============================================================================
// tb_mdu_seq : directed + randomized self-checking bench for mdu_seq (WIDTH=32)
// Rev 1.0
// ============================================================================
module tb_mdu_seq;
  localparam int W = 32;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  mdu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .flush(flush),
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // Reference arithmetic straight from the ISA definitions.
  function automatic void ref_result(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                     output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
    logic [63:0] p;
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    dz = 1'b0;
    p  = '0;
    case (o)
      3'b000:  p = {32'b0, x} * {32'b0, y};
      3'b001:  p = sx * sy;
      default: begin
        if (y == 0) begin
          p  = {x, 32'hFFFF_FFFF};
          dz = 1'b1;
        end else if (o == 3'b010) begin
          p = {x % y, x / y};
        end else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    h = p[63:32];
    l = p[31:0];
  endfunction

  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic         m_dz = 1'b0, p_dz = 1'b0, m_done = 1'b0;
  int           m_rem = 0;

  // Model: an accepted op completes W+1 edges later unless flushed.
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_hi = '0; m_lo = '0; m_dz = 1'b0; m_done = 1'b0; m_rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        if (flush) m_rem = 0;
        else begin
          m_rem--;
          if (m_rem == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; m_done = 1'b1;
          end
        end
      end else if (start) begin
        if (op == 3'b100) begin
          m_hi = a; m_dz = 1'b0; m_done = 1'b1;
        end else if (op == 3'b101) begin
          m_lo = a; m_dz = 1'b0; m_done = 1'b1;
        end else if (op[2:1] == 2'b00 || (op[2:1] == 2'b01 && DIV_EN)) begin
          ref_result(op, a, b, p_hi, p_lo, p_dz);
          m_dz  = 1'b0;
          m_rem = W + 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (checking) begin
      chk("cyc_busy", busy, m_rem > 0);
      chk("cyc_done", done, m_done);
      chk("cyc_divzero", div_zero, m_dz);
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom % 8)
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      4:       return W'($urandom % 16);
      default: return W'($urandom);
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge with inputs scrambled.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    lat = 0; nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat, nb, dn, bz;
  logic [2:0] rop;

  initial begin
    #1 rst = 1'b0;
    checking = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_divzero", div_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, nb);
    chk("t1_latency", lat, W + 1);
    chk("t1_busy_cycles", nb, W + 1);
    chk("t1_hi", hi, 32'hFFFF_FFFE);
    chk("t1_lo", lo, 32'h0000_0001);
    @(posedge clk); #1;
    chk("t1_done_pulse", done, 0);

    issue(3'b001, 32'hFFFF_FFFD, 32'd7);
    wait_done(lat, nb);
    chk("t2_mult_hi", hi, 32'hFFFF_FFFF);
    chk("t2_mult_lo", lo, 32'hFFFF_FFEB);
`ifdef MDU_DIV_EN
    issue(3'b010, 32'd100, 32'd7);
    wait_done(lat, nb);
    chk("t2_b2b_latency", lat, W + 1);
    chk("t2_divu_lo", lo, 32'd14);
    chk("t2_divu_hi", hi, 32'd2);
    @(posedge clk); #1;
    issue(3'b011, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, nb);
    chk("t3_div_lo", lo, 32'hFFFF_FFFD);
    chk("t3_div_hi", hi, 32'hFFFF_FFFF);
    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, nb);
    chk("t3_minneg1_lo", lo, 32'h8000_0000);
    chk("t3_minneg1_hi", hi, 32'h0);
    issue(3'b010, 32'd5, 32'd0);
    wait_done(lat, nb);
    chk("t4_dz_latency", lat, W + 1);
    chk("t4_dz_flag", div_zero, 1);
    chk("t4_dz_hi", hi, 32'd5);
    chk("t4_dz_lo", lo, 32'hFFFF_FFFF);
    rop = 3'b011;
`else
    issue(3'b000, 32'd100, 32'd7);
    wait_done(lat, nb);
    chk("t2_b2b_latency", lat, W + 1);
    chk("t2_b2b_lo", lo, 32'd700);
    chk("t2_b2b_hi", hi, 32'd0);
    @(posedge clk); #1;
    issue(3'b011, 32'd5, 32'd2);
    dn = 0; bz = 0;
    repeat (5) begin
      if (busy) bz++;
      if (done) dn++;
      @(posedge clk); #1;
    end
    chk("t6_nodiv_busy", bz, 0);
    chk("t6_nodiv_done", dn, 0);
    rop = 3'b000;
`endif
    issue(3'b101, 32'h1234, 32'h0);
    wait_done(lat, nb);
    chk("t4_mtlo_latency", lat, 0);
    chk("t4_mtlo_busy", nb, 0);
    chk("t4_mtlo_lo", lo, 32'h1234);
    chk("t4_mtlo_divzero", div_zero, 0);
    @(posedge clk); #1;
    issue(3'b100, 32'hCAFE, 32'h0);
    wait_done(lat, nb);
    chk("t4_mthi_hi", hi, 32'hCAFE);

    @(posedge clk); #1;
    issue(3'b000, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 3'b100; a = 32'hDEAD;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("t5_flush_busy", busy, 0);
    dn = 0;
    repeat (40) begin
      if (done) dn++;
      @(posedge clk); #1;
    end
    chk("t5_flush_nodone", dn, 0);
    chk("t5_flush_hi", hi, 32'hCAFE);
    chk("t5_flush_lo", lo, 32'h1234);

    issue(rop, 32'h8765_4321, 32'h13);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_rst_hi", hi, 0);
    chk("t6_rst_lo", lo, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      start = ($urandom % 3) == 0;
      op    = 3'($urandom);
      a     = pick();
      b     = pick();
      flush = ($urandom % 50) == 0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
